x_bus_rv32i: RTL

Memory-side bus responder directly downstream of the rv32i core's memory port. It receives the core's single-outstanding valid/rnw/addr/data requests and returns the accept strobe and read data. It decodes each request to one of three targets: on-chip word RAM (one wait state on reads), a small peripheral register set (GPIO, cycle counter), or a byte-stream TX FIFO.

---
 rtl/x_bus_rv32i_pkg.sv | 25 ++
 rtl/x_sync_fifo.sv | 64 ++++++
 rtl/x_bus_rv32i.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/x_bus_rv32i_pkg.sv
// Shared constants, state encoding and lane-rotation helper for the x_bus_rv32i responder.
package x_bus_rv32i_pkg;

  localparam logic [3:0]  RAM_TAG     = 4'h0;
  localparam logic [31:0] PERIPH_BASE = 32'h8000_0000;

  localparam logic [3:0] GPIO_OFF   = 4'h0;
  localparam logic [3:0] CYCLE_OFF  = 4'h4;
  localparam logic [3:0] TXDATA_OFF = 4'h8;
  localparam logic [3:0] TXSTAT_OFF = 4'hC;

  typedef enum logic {IDLE, RDWAIT} state_e;

  function automatic logic [31:0] rotr_lane(input logic [31:0] d, input logic [1:0] lane);
    logic [31:0] r;
    case (lane)
      2'd1:    r = {d[7:0],  d[31:8]};
      2'd2:    r = {d[15:0], d[31:16]};
      2'd3:    r = {d[23:0], d[31:24]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/x_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; DEPTH must be a power of two.
module x_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = i_push & ~full_q;
  assign do_pop  = i_pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= i_data;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      count_q <= count_d;
      // Flags are registered, so a pop only frees a slot for pushes on the next cycle.
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign o_data  = mem_q[rd_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

endmodule

// File: rtl/x_bus_rv32i.sv
// Memory-side responder for the rv32i core: word RAM, GPIO/CYCLE registers and a TX byte FIFO.
// Optional read-lane rotation is enabled by defining X_BUS_RV32I_LANE_SHIFT_EN.
module x_bus_rv32i
  import x_bus_rv32i_pkg::*;
#(
  parameter int AW       = 10,
  parameter int TX_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  output logic [31:0] o_gpio,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  state_e         state_q, state_d;
  logic [31:0]    gpio_q, cycle_q;
  logic [31:0]    mem [2**AW];
  logic [31:0]    ram_rdata_q;
  logic [AW-1:0]  ram_idx;

  logic           is_ram, is_periph;
  logic [3:0]     reg_off;
  logic           sel_gpio, sel_cycle, sel_txdata, sel_txstat;

  logic           accept, ram_re, ram_we, gpio_we, cycle_we, tx_push;
  logic [31:0]    rdata;

  logic           tx_full, tx_empty, tx_pop;
  logic [CW-1:0]  tx_count;

  assign ram_idx    = i_addr[AW+1:2];
  assign is_ram     = (i_addr[31:28] == RAM_TAG);
  assign is_periph  = (i_addr[31:4] == PERIPH_BASE[31:4]);
  assign reg_off    = {i_addr[3:2], 2'b00};
  assign sel_gpio   = is_periph && (reg_off == GPIO_OFF);
  assign sel_cycle  = is_periph && (reg_off == CYCLE_OFF);
  assign sel_txdata = is_periph && (reg_off == TXDATA_OFF);
  assign sel_txstat = is_periph && (reg_off == TXSTAT_OFF);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rdata    = '0;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    gpio_we  = 1'b0;
    cycle_we = 1'b0;
    tx_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (is_ram) begin
            if (i_rnw) begin
              ram_re  = 1'b1;
              state_d = RDWAIT;
            end else begin
              ram_we = 1'b1;
              accept = 1'b1;
            end
          end else begin
            accept = 1'b1;
            if (i_rnw) begin
              if (sel_gpio)   rdata = gpio_q;
              if (sel_cycle)  rdata = cycle_q;
              if (sel_txstat) rdata = {16'h0, 8'(tx_count), 6'b0, tx_empty, tx_full};
            end else begin
              gpio_we  = sel_gpio;
              cycle_we = sel_cycle;
              if (sel_txdata) begin
                if (tx_full) accept  = 1'b0;
                else         tx_push = 1'b1;
              end
            end
          end
        end
      end
      RDWAIT: begin
        accept  = 1'b1;
        rdata   = ram_rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset squashes any response, including a read pending in RDWAIT.
    if (i_rst) begin
      state_d  = IDLE;
      accept   = 1'b0;
      ram_re   = 1'b0;
      ram_we   = 1'b0;
      gpio_we  = 1'b0;
      cycle_we = 1'b0;
      tx_push  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      gpio_q  <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      if (gpio_we) gpio_q <= i_data;
      cycle_q <= cycle_we ? i_data : cycle_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ram_we) mem[ram_idx] <= i_data;
    if (ram_re) ram_rdata_q <= mem[ram_idx];
  end

`ifdef X_BUS_RV32I_LANE_SHIFT_EN
  logic [1:0] lane_q, lane;

  // The byte lane of a RAM read must survive into RDWAIT, where i_addr is not looked at.
  always_ff @(posedge i_clk) begin
    if (ram_re) lane_q <= i_addr[1:0];
  end

  assign lane   = (state_q == RDWAIT) ? lane_q : i_addr[1:0];
  assign o_data = accept ? rotr_lane(rdata, lane) : 32'h0;
`else
  logic unused_lane_bits;
  assign unused_lane_bits = ^i_addr[1:0];
  assign o_data = accept ? rdata : 32'h0;
`endif

  assign tx_pop = ~tx_empty & i_tx_ready;

  x_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (tx_push),
    .i_data  (i_data[7:0]),
    .i_pop   (tx_pop),
    .o_data  (o_tx_data),
    .o_full  (tx_full),
    .o_empty (tx_empty),
    .o_count (tx_count)
  );

  assign o_accept   = accept;
  assign o_gpio     = gpio_q;
  assign o_tx_valid = ~tx_empty;

endmodule
